// File: rtl/mac_cluster_ctrl_if.sv
// Purpose: bundles the mac_cluster_ctrl job config, status, operand/result handshakes and cluster/cache controls.
// Latency: none; signal grouping only.
// Backpressure: op_valid/op_ready in from the operand buffer, res_valid/res_ready out to writeback.
// Ports: master = controller side (drives status, strobes, addresses); slave = environment side (drives cfg, op_valid, res_ready).
interface mac_cluster_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int PASS_W = 8
);
  // job configuration and status
  logic              cfg_start;
  logic [ADDR_W:0]   cfg_num_out;
  logic [PASS_W-1:0] cfg_num_pass;
  logic              cfg_add_bias;
  logic              cfg_relu;
  logic              busy;
  logic              job_done;
  // operand in / result out handshakes
  logic              op_valid;
  logic              op_ready;
  logic              res_valid;
  logic              res_ready;
  // MAC cluster controls
  logic              mac_en;
  logic              mac_add_bias;
  logic              mac_relu;
  logic              mac_done;
  // psum cache controls
  logic              cache_clear_n;
  logic              cache_wr_en;
  logic [ADDR_W-1:0] cache_rd_addr;
  logic [ADDR_W-1:0] cache_wr_addr;
  // position / pass indices for operand buffer addressing
  logic [ADDR_W-1:0] cur_pos;
  logic [PASS_W-1:0] cur_pass;

  modport master (
    input  cfg_start, cfg_num_out, cfg_num_pass, cfg_add_bias, cfg_relu,
    input  op_valid, res_ready,
    output busy, job_done, op_ready, res_valid,
    output mac_en, mac_add_bias, mac_relu, mac_done,
    output cache_clear_n, cache_wr_en, cache_rd_addr, cache_wr_addr,
    output cur_pos, cur_pass
  );

  modport slave (
    output cfg_start, cfg_num_out, cfg_num_pass, cfg_add_bias, cfg_relu,
    output op_valid, res_ready,
    input  busy, job_done, op_ready, res_valid,
    input  mac_en, mac_add_bias, mac_relu, mac_done,
    input  cache_clear_n, cache_wr_en, cache_rd_addr, cache_wr_addr,
    input  cur_pos, cur_pass
  );
endinterface

// File: rtl/mac_cluster_ctrl.sv
// Purpose: job sequencer for one MAC cluster and its local psum cache (positions x passes).
// Latency: start at T -> cache clear T+1 -> first operand T+2; best-case job_done T+2+num_out*num_pass.
// Backpressure: no operand fires without op_valid; final-pass operands also wait for res_ready.
// Ports: i_clk clock; i_rst_n synchronous active-low reset; ctrl_if (master) carries cfg/status,
//        operand and result handshakes, MAC cluster strobes and psum cache controls.
module mac_cluster_ctrl #(
  parameter int NUM_POS = 32,
  parameter int ADDR_W  = 5,
  parameter int PASS_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mac_cluster_ctrl_if.master   ctrl_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_OUT = (ADDR_W+1)'(NUM_POS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pos;
  logic [PASS_W-1:0] r_pass;
  logic [ADDR_W:0]   r_num_out;
  logic [PASS_W-1:0] r_num_pass;
  logic              r_add_bias;
  logic              r_relu;

  logic [ADDR_W:0]   w_num_out_clamp;
  logic              w_empty;
  logic              w_start;
  logic              w_last;
  logic              w_pos_last;
  logic              w_fire;

  logic              w_busy;
  logic              w_job_done;
  logic              w_op_ready;
  logic              w_res_valid;
  logic              w_mac_en;
  logic              w_mac_add_bias;
  logic              w_mac_relu;
  logic              w_mac_done;
  logic              w_cache_clear_n;
  logic              w_cache_wr_en;

  assign w_num_out_clamp = (ctrl_if.cfg_num_out > MAX_OUT) ? MAX_OUT : ctrl_if.cfg_num_out;
  assign w_empty         = (ctrl_if.cfg_num_out == '0) || (ctrl_if.cfg_num_pass == '0);
  assign w_start         = (r_state == S_IDLE) && ctrl_if.cfg_start;

  assign w_last     = (r_pass == (r_num_pass - PASS_W'(1)));
  assign w_pos_last = ({1'b0, r_pos} == (r_num_out - (ADDR_W+1)'(1)));
  // Final pass needs writeback to take the result before the operand is consumed.
  assign w_fire     = (r_state == S_RUN) && ctrl_if.op_valid && (!w_last || ctrl_if.res_ready);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_busy          = 1'b0;
    w_job_done      = 1'b0;
    w_op_ready      = 1'b0;
    w_res_valid     = 1'b0;
    w_mac_en        = 1'b0;
    w_mac_add_bias  = 1'b0;
    w_mac_relu      = 1'b0;
    w_mac_done      = 1'b0;
    w_cache_clear_n = 1'b1;
    w_cache_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_if.cfg_start) begin
          // Empty jobs skip the cache entirely and just report completion.
          w_state_nxt = w_empty ? S_FINISH : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_busy          = 1'b1;
        w_cache_clear_n = 1'b0;
        w_state_nxt     = S_RUN;
      end
      S_RUN: begin
        w_busy         = 1'b1;
        w_op_ready     = w_fire;
        w_mac_en       = w_fire;
        w_res_valid    = w_last && ctrl_if.op_valid;
        // The final pass goes straight to writeback, so its psum is never stored.
        w_cache_wr_en  = w_fire && !w_last;
        w_mac_add_bias = r_add_bias && w_last;
        w_mac_relu     = r_relu && w_last;
        w_mac_done     = w_fire && w_last;
        if (w_fire && w_last && w_pos_last) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_busy      = 1'b1;
        w_job_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Job config latch and position/pass counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pos      <= '0;
      r_pass     <= '0;
      r_num_out  <= '0;
      r_num_pass <= '0;
      r_add_bias <= 1'b0;
      r_relu     <= 1'b0;
    end else if (w_start) begin
      r_pos      <= '0;
      r_pass     <= '0;
      r_num_out  <= w_num_out_clamp;
      r_num_pass <= ctrl_if.cfg_num_pass;
      r_add_bias <= ctrl_if.cfg_add_bias;
      r_relu     <= ctrl_if.cfg_relu;
    end else if (w_fire) begin
      if (!w_pos_last) begin
        r_pos <= r_pos + ADDR_W'(1);
      end else if (!w_last) begin
        // Position wraps only at a pass boundary.
        r_pos  <= '0;
        r_pass <= r_pass + PASS_W'(1);
      end else begin
        // Final fire: park counters at 0 so idle addresses read as 0.
        r_pos  <= '0;
        r_pass <= '0;
      end
    end
  end

  assign ctrl_if.busy          = w_busy;
  assign ctrl_if.job_done      = w_job_done;
  assign ctrl_if.op_ready      = w_op_ready;
  assign ctrl_if.res_valid     = w_res_valid;
  assign ctrl_if.mac_en        = w_mac_en;
  assign ctrl_if.mac_add_bias  = w_mac_add_bias;
  assign ctrl_if.mac_relu      = w_mac_relu;
  assign ctrl_if.mac_done      = w_mac_done;
  assign ctrl_if.cache_clear_n = w_cache_clear_n;
  assign ctrl_if.cache_wr_en   = w_cache_wr_en;
  // Read and write share the current position; the read is combinational, the write lands at the edge.
  assign ctrl_if.cache_rd_addr = r_pos;
  assign ctrl_if.cache_wr_addr = r_pos;
  assign ctrl_if.cur_pos       = r_pos;
  assign ctrl_if.cur_pass      = r_pass;

endmodule
